logic_result_buffer: RTL and testbench

Two-entry registered output stage directly downstream of the logic unit: captures the W-bit result and its N/Z flags under a valid/ready handshake. It decouples the combinational logic unit from the consumer (register file or bus writer). It also keeps saturating counts of zero and negative results for debug. There is no combinational path from any input-side signal to any output-side data signal.

---
 rtl/logic_result_buffer.sv | 135 +++++++++++++
 tb/tb_logic_result_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/logic_result_buffer.sv
// logic_result_buffer: two-entry registered output stage behind the logic
// unit. Holds {DATA, N, Z} per slot under a valid/ready handshake and keeps
// saturating debug counts of accepted zero and negative results.
// Optional feature macro: LRB_FLAG_CHECK_EN (flag-consistency checking;
// when undefined FLAG_ERR is tied to 0).
module logic_result_buffer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [W-1:0]     IN_DATA,
    input  logic             IN_N,
    input  logic             IN_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [W-1:0]     OUT_DATA,
    output logic             OUT_N,
    output logic             OUT_Z,
    output logic [1:0]       LEVEL,
    input  logic             CLR_COUNT,
    output logic [CNT_W-1:0] Z_COUNT,
    output logic [CNT_W-1:0] N_COUNT,
    output logic             FLAG_ERR
);

    // State encoding doubles as the occupancy value driven on LEVEL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t       state;
    logic [W-1:0] slot_data [2];
    logic [1:0]   slot_n;
    logic [1:0]   slot_z;
    logic         head;
    logic         tail;
    logic         push;
    logic         pop;

    // Handshake qualifiers; everything here is decoded from registers or RST,
    // so nothing on the input side reaches the output data.
    always_comb begin
        IN_READY  = (state != FULL) & ~RST;
        OUT_VALID = (state != EMPTY) & ~RST;
        push      = IN_VALID & IN_READY;
        pop       = OUT_VALID & OUT_READY;
        LEVEL     = RST ? 2'd0 : state;
    end

    // Head slot presented to the consumer, masked to zero when nothing is valid.
    always_comb begin
        OUT_DATA = '0;
        OUT_N    = 1'b0;
        OUT_Z    = 1'b0;
        if (OUT_VALID) begin
            OUT_DATA = slot_data[head];
            OUT_N    = slot_n[head];
            OUT_Z    = slot_z[head];
        end
    end

    // Occupancy FSM and ring pointers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= FULL;
                    else if (pop && !push) state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Slot storage; contents need no reset because outputs are masked.
    always_ff @(posedge CLK) begin
        if (push) begin
            slot_data[tail] <= IN_DATA;
            slot_n[tail]    <= IN_N;
            slot_z[tail]    <= IN_Z;
        end
    end

    // Saturating Z/N event counters; a clear still counts the current push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Z_COUNT <= '0;
            N_COUNT <= '0;
        end else if (CLR_COUNT) begin
            Z_COUNT <= CNT_W'(push & IN_Z);
            N_COUNT <= CNT_W'(push & IN_N);
        end else if (push) begin
            if (IN_Z && Z_COUNT != CNT_MAX) Z_COUNT <= Z_COUNT + 1'b1;
            if (IN_N && N_COUNT != CNT_MAX) N_COUNT <= N_COUNT + 1'b1;
        end
    end

`ifdef LRB_FLAG_CHECK_EN
    logic exp_n;
    logic exp_z;

    // Flags the logic unit should have produced for the offered data.
    always_comb begin
        exp_n = IN_DATA[W-1];
        exp_z = (IN_DATA == '0);
    end

    // Sticky error on any accepted entry whose supplied flags disagree.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FLAG_ERR <= 1'b0;
        end else if (push && ((IN_N != exp_n) || (IN_Z != exp_z))) begin
            FLAG_ERR <= 1'b1;
        end
    end
`else
    assign FLAG_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_buffer.sv
// tb_logic_result_buffer: directed scoreboard bench for logic_result_buffer
// (instantiated with CNT_W=2 so counter saturation is reachable quickly).
module tb_logic_result_buffer;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     IN_DATA;
    logic             IN_N;
    logic             IN_Z;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [W-1:0]     OUT_DATA;
    logic             OUT_N;
    logic             OUT_Z;
    logic [1:0]       LEVEL;
    logic             CLR_COUNT;
    logic [CNT_W-1:0] Z_COUNT;
    logic [CNT_W-1:0] N_COUNT;
    logic             FLAG_ERR;

    logic_result_buffer #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .IN_N(IN_N), .IN_Z(IN_Z),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_N(OUT_N), .OUT_Z(OUT_Z),
        .LEVEL(LEVEL), .CLR_COUNT(CLR_COUNT),
        .Z_COUNT(Z_COUNT), .N_COUNT(N_COUNT), .FLAG_ERR(FLAG_ERR)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] q[$];          // {data, n, z} in expected output order
    int         zc = 0;
    int         nc = 0;
    logic       err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("level",    32'(LEVEL),    32'(q.size()));
        chk("z_count",  32'(Z_COUNT),  32'(zc));
        chk("n_count",  32'(N_COUNT),  32'(nc));
        chk("flag_err", 32'(FLAG_ERR), 32'(err));
    endtask

    // One clock cycle: check registered state, drive inputs, check the
    // handshake/head outputs, update the model, then cross the rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic n,
                        input logic z, input logic ordy, input logic clr);
        bit pushing;
        bit popping;
        @(negedge CLK);
        check_regs();
        IN_VALID  = v;
        IN_DATA   = d;
        IN_N      = n;
        IN_Z      = z;
        OUT_READY = ordy;
        CLR_COUNT = clr;
        #1;
        chk("in_ready",  32'(IN_READY),  32'(q.size() < 2));
        chk("out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 32'(OUT_DATA), 32'(q[0][5:2]));
            chk("out_n",    32'(OUT_N),    32'(q[0][1]));
            chk("out_z",    32'(OUT_Z),    32'(q[0][0]));
        end
        pushing = v && (q.size() < 2);
        popping = ordy && (q.size() > 0);
        if (popping) void'(q.pop_front());
        if (pushing) q.push_back({d, n, z});
        if (clr) begin
            zc = (pushing && z) ? 1 : 0;
            nc = (pushing && n) ? 1 : 0;
        end else if (pushing) begin
            if (z && zc != 3) zc++;
            if (n && nc != 3) nc++;
        end
`ifdef LRB_FLAG_CHECK_EN
        if (pushing && ((n != d[W-1]) || (z != (d == 4'h0)))) err = 1'b1;
`endif
        @(posedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_N = 1'b0; IN_Z = 1'b0;
        OUT_READY = 1'b0; CLR_COUNT = 1'b0;
        #1;
        chk("rst_in_ready",  32'(IN_READY),  32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_data",  32'(OUT_DATA),  32'd0);
        chk("rst_level",     32'(LEVEL),     32'd0);
        @(posedge CLK);
        q.delete();
        zc = 0; nc = 0; err = 1'b0;
        @(negedge CLK);
        check_regs();
        chk("rst_out_valid2", 32'(OUT_VALID), 32'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        logic [W-1:0] d;

        // Reset, then a single pass-through entry.
        do_reset();
        step(1, 4'hA, 1, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);

        // Fill with consumer stalled, refused third push, then drain in order.
        step(1, 4'h3, 0, 0, 0, 0);
        step(1, 4'h0, 0, 1, 0, 0);
        step(1, 4'h5, 0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0);
        step(0, 4'h0, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);

        // Level 1 with simultaneous push and pop, 20 back-to-back transfers.
        step(1, 4'h7, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            d = 4'($urandom_range(0, 15));
            step(1, d, d[W-1], d == 4'h0, 1, 0);
        end
        step(0, 4'h0, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);

        // Z counter saturation, then clear together with a Z=1 push.
        step(0, 4'h0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 4'h0, 0, 1, 1, 0);
        @(negedge CLK);
        chk("z_sat", 32'(Z_COUNT), 32'd3);
        step(1, 4'h0, 0, 1, 1, 1);
        @(negedge CLK);
        chk("z_clr_push", 32'(Z_COUNT), 32'd1);
        step(0, 4'h0, 0, 0, 1, 0);

        // Reset while full.
        step(1, 4'h9, 1, 0, 0, 0);
        step(1, 4'hC, 1, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0);
        do_reset();

        // Inconsistent flags (zero data, Z=0), then consistent pushes.
        step(1, 4'h0, 0, 0, 1, 0);
        step(1, 4'h8, 1, 0, 1, 0);
        step(1, 4'h1, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 1, 0);
        @(negedge CLK);
`ifdef LRB_FLAG_CHECK_EN
        chk("flag_err_sticky", 32'(FLAG_ERR), 32'd1);
`else
        chk("flag_err_tied", 32'(FLAG_ERR), 32'd0);
`endif
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
